// File: rtl/gate_test_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : gate_test_ctrl
// Description : Exhaustive tester for a 2-input combinational gate. A sweep
//               drives the four input vectors {a,b} = 00,01,10,11, waits
//               SETTLE cycles on each and then samples f against a latched
//               4-bit truth table. It reports per-vector mismatches and an
//               overall pass flag.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   SETTLE     wait cycles per vector before f is sampled (0..15)
// Ports
//   clk        single clock, all state changes on its rising edge
//   rst_n      synchronous active-low reset
//   start      begin a sweep (honoured in IDLE only)
//   abort      terminate an active sweep
//   truth_tbl  expected f; bit i applies to vector i = {a,b}
//   f          output of the gate under test
//   a, b       gate inputs (vector index bits 1 and 0)
//   busy       sweep in progress
//   done       one-cycle pulse at sweep completion
//   pass       sweep result, valid from done until the next accepted start
//   fail_mask  bit i set when vector i mismatched
// ============================================================================
module gate_test_ctrl #(
  parameter int unsigned SETTLE = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic [3:0] truth_tbl,
  input  logic       f,
  output logic       a,
  output logic       b,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] fail_mask
);

  localparam logic [1:0] C_ST_IDLE   = 2'd0;
  localparam logic [1:0] C_ST_WAIT   = 2'd1;
  localparam logic [1:0] C_ST_SAMPLE = 2'd2;
  localparam logic [1:0] C_ST_DONE   = 2'd3;

  // With no settle time every vector goes straight to SAMPLE.
  localparam bit         C_NO_SETTLE = (SETTLE == 0);
  // The WAIT counter is loaded with SETTLE-1 so WAIT lasts SETTLE cycles.
  localparam logic [3:0] C_CNT_LOAD  = (SETTLE > 0) ? 4'(SETTLE - 1) : 4'd0;

  logic [1:0] r_state;
  logic [1:0] w_next_state;
  logic [1:0] r_idx;
  logic [3:0] r_cnt;
  logic [3:0] r_tbl;
  logic [3:0] r_fail_mask;
  logic       r_pass;
  logic       w_accept;

  assign w_accept = start && !abort;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= C_ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      C_ST_IDLE: begin
        if (w_accept) begin
          w_next_state = C_NO_SETTLE ? C_ST_SAMPLE : C_ST_WAIT;
        end
      end
      C_ST_WAIT: begin
        if (abort) begin
          w_next_state = C_ST_IDLE;
        end else if (r_cnt == 4'd0) begin
          w_next_state = C_ST_SAMPLE;
        end
      end
      C_ST_SAMPLE: begin
        if (abort) begin
          w_next_state = C_ST_IDLE;
        end else if (r_idx == 2'd3) begin
          w_next_state = C_ST_DONE;
        end else begin
          w_next_state = C_NO_SETTLE ? C_ST_SAMPLE : C_ST_WAIT;
        end
      end
      default: begin
        w_next_state = C_ST_IDLE;
      end
    endcase
  end

  // Sweep datapath: vector index, settle counter, latched table, results.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_idx       <= 2'd0;
      r_cnt       <= 4'd0;
      r_tbl       <= 4'd0;
      r_fail_mask <= 4'd0;
      r_pass      <= 1'b0;
    end else begin
      case (r_state)
        C_ST_IDLE: begin
          if (w_accept) begin
            r_tbl       <= truth_tbl;
            r_idx       <= 2'd0;
            r_cnt       <= C_CNT_LOAD;
            r_fail_mask <= 4'd0;
            r_pass      <= 1'b0;
          end
        end
        C_ST_WAIT: begin
          if (abort) begin
            r_idx  <= 2'd0;
            r_pass <= 1'b0;
          end else if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        C_ST_SAMPLE: begin
          // An abort discards the compare of the vector being sampled.
          if (abort) begin
            r_idx  <= 2'd0;
            r_pass <= 1'b0;
          end else begin
            if (f != r_tbl[r_idx]) begin
              r_fail_mask[r_idx] <= 1'b1;
            end
            if (r_idx != 2'd3) begin
              r_idx <= r_idx + 2'd1;
              r_cnt <= C_CNT_LOAD;
            end
          end
        end
        default: begin
          // DONE: capture the verdict so it holds through IDLE.
          r_pass <= (r_fail_mask == 4'd0);
          r_idx  <= 2'd0;
        end
      endcase
    end
  end

  // Output logic
  always_comb begin
    a         = 1'b0;
    b         = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    pass      = r_pass;
    fail_mask = r_fail_mask;
    case (r_state)
      C_ST_WAIT, C_ST_SAMPLE: begin
        a    = r_idx[1];
        b    = r_idx[0];
        busy = 1'b1;
      end
      C_ST_DONE: begin
        done = 1'b1;
        pass = (r_fail_mask == 4'd0);
      end
      default: begin
        pass = r_pass;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_gate_test_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_gate_test_ctrl
// Description : Bench for gate_test_ctrl. Two instances (SETTLE=0 and
//               SETTLE=1) share stimulus; a sweep-timeline model predicts
//               every output each cycle, and directed scenarios add literal
//               expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gate_test_ctrl;

  localparam int C_MD_AND = 0;
  localparam int C_MD_OR  = 1;
  localparam int C_MD_S0  = 2;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       abort;
  logic [3:0] truth_tbl;
  int         mode;

  // Index 0: SETTLE=0 instance, index 1: SETTLE=1 instance.
  logic       d_f    [2];
  logic       d_a    [2];
  logic       d_b    [2];
  logic       d_busy [2];
  logic       d_done [2];
  logic       d_pass [2];
  logic [3:0] d_fm   [2];

  int n_checks;
  int n_fail;
  bit cmp_on;

  // Model: sweep position k counts cycles since the accepting edge.
  bit         m_act  [2];
  bit         m_done [2];
  bit         m_pass [2];
  int         m_k    [2];
  logic [3:0] m_mask [2];
  logic [3:0] m_tbl  [2];

  int         busy_n  [2];
  int         done_n  [2];
  int         done_at [2];
  logic [1:0] ab_seq  [8];

  function automatic logic gate_f(input int md, input int v);
    case (md)
      C_MD_AND: return (v == 3);
      C_MD_OR:  return (v != 0);
      C_MD_S0:  return 1'b0;
      default:  return 1'b1;
    endcase
  endfunction

  assign d_f[0] = gate_f(mode, int'({d_a[0], d_b[0]}));
  assign d_f[1] = gate_f(mode, int'({d_a[1], d_b[1]}));

  gate_test_ctrl #(.SETTLE(0)) u_s0 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .truth_tbl(truth_tbl), .f(d_f[0]), .a(d_a[0]), .b(d_b[0]),
    .busy(d_busy[0]), .done(d_done[0]), .pass(d_pass[0]), .fail_mask(d_fm[0])
  );

  gate_test_ctrl #(.SETTLE(1)) u_s1 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .truth_tbl(truth_tbl), .f(d_f[1]), .a(d_a[1]), .b(d_b[1]),
    .busy(d_busy[1]), .done(d_done[1]), .pass(d_pass[1]), .fail_mask(d_fm[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int inst, input logic [3:0] got,
                     input logic [3:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s inst%0d: actual=%0h required=%0h (t=%0t)", nm, inst, got, exp, $time);
    end
  endtask

  // Advance the model across one rising edge using the inputs seen there.
  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      int per;
      int v;
      per = i + 1;
      if (!rst_n) begin
        m_act[i] = 1'b0; m_done[i] = 1'b0; m_pass[i] = 1'b0;
        m_k[i] = 0; m_mask[i] = 4'd0;
      end else if (m_done[i]) begin
        m_done[i] = 1'b0;
      end else if (!m_act[i]) begin
        if (start && !abort) begin
          m_act[i] = 1'b1; m_k[i] = 0; m_tbl[i] = truth_tbl;
          m_mask[i] = 4'd0; m_pass[i] = 1'b0;
        end
      end else if (abort) begin
        m_act[i] = 1'b0; m_pass[i] = 1'b0;
      end else begin
        v = m_k[i] / per;
        if ((m_k[i] % per) == per - 1) begin
          if (gate_f(mode, v) != m_tbl[i][v]) m_mask[i][v] = 1'b1;
        end
        m_k[i]++;
        if (m_k[i] == 4 * per) begin
          m_act[i] = 1'b0; m_done[i] = 1'b1;
          m_pass[i] = (m_mask[i] == 4'd0);
        end
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (cmp_on) begin
      for (int i = 0; i < 2; i++) begin
        int v;
        v = m_k[i] / (i + 1);
        chk("a",    i, 4'(d_a[i]),    m_act[i] ? 4'((v >> 1) & 1) : 4'd0);
        chk("b",    i, 4'(d_b[i]),    m_act[i] ? 4'(v & 1) : 4'd0);
        chk("busy", i, 4'(d_busy[i]), 4'(m_act[i]));
        chk("done", i, 4'(d_done[i]), 4'(m_done[i]));
        chk("pass", i, 4'(d_pass[i]), 4'(m_pass[i]));
        chk("fmask", i, d_fm[i],      m_mask[i]);
      end
    end
  end

  // One start pulse, then ncyc observed cycles; optional events at cycle n.
  task automatic run(input int ncyc, input int repulse, input int abort_at,
                     input int rst_at, input int tbl_chg_at);
    for (int i = 0; i < 2; i++) begin
      busy_n[i] = 0; done_n[i] = 0; done_at[i] = 0;
    end
    start = 1'b1;
    cyc();
    start = 1'b0;
    for (int n = 1; n <= ncyc; n++) begin
      for (int i = 0; i < 2; i++) begin
        if (d_busy[i]) busy_n[i]++;
        if (d_done[i]) begin done_n[i]++; done_at[i] = n; end
      end
      if (n <= 8) ab_seq[n-1] = {d_a[1], d_b[1]};
      if (n == repulse)    start = 1'b1;
      if (n == abort_at)   abort = 1'b1;
      if (n == rst_at)     rst_n = 1'b0;
      if (n == tbl_chg_at) truth_tbl = 4'b0000;
      cyc();
      start = 1'b0;
      abort = 1'b0;
      rst_n = 1'b1;
    end
  endtask

  logic [1:0] exp_ab [8];

  initial begin
    exp_ab = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3};
    n_checks = 0; n_fail = 0; cmp_on = 1'b0;
    for (int i = 0; i < 2; i++) begin
      m_act[i] = 1'b0; m_done[i] = 1'b0; m_pass[i] = 1'b0;
      m_k[i] = 0; m_mask[i] = 4'd0; m_tbl[i] = 4'd0;
    end
    rst_n = 1'b0; start = 1'b1; abort = 1'b0; truth_tbl = 4'b1000; mode = C_MD_AND;
    cyc();
    start = 1'b0;
    cyc();
    cmp_on = 1'b1;
    for (int i = 0; i < 2; i++) begin
      chk("rst_busy", i, 4'(d_busy[i]), 4'd0);
      chk("rst_pass", i, 4'(d_pass[i]), 4'd0);
      chk("rst_fm",   i, d_fm[i],       4'd0);
    end
    rst_n = 1'b1;
    cyc();

    // AND gate, correct table; table overwritten mid-sweep must not matter.
    run(12, 0, 0, 0, 3);
    truth_tbl = 4'b1000;
    chk("s1_busy_cycles", 1, 4'(busy_n[1]),  4'd8);
    chk("s1_done_at",     1, 4'(done_at[1]), 4'd9);
    chk("s1_done_cnt",    1, 4'(done_n[1]),  4'd1);
    chk("s1_pass",        1, 4'(d_pass[1]),  4'd1);
    chk("s1_fm",          1, d_fm[1],        4'b0000);
    chk("s0_busy_cycles", 0, 4'(busy_n[0]),  4'd4);
    chk("s0_done_at",     0, 4'(done_at[0]), 4'd5);
    chk("s0_pass",        0, 4'(d_pass[0]),  4'd1);
    for (int n = 0; n < 8; n++) chk("ab_seq", 1, 4'(ab_seq[n]), 4'(exp_ab[n]));

    // f stuck at 0
    mode = C_MD_S0;
    run(12, 0, 0, 0, 0);
    chk("stuck0_pass", 1, 4'(d_pass[1]), 4'd0);
    chk("stuck0_fm",   1, d_fm[1],       4'b1000);
    chk("stuck0_fm",   0, d_fm[0],       4'b1000);

    // OR gate against AND table
    mode = C_MD_OR;
    run(12, 0, 0, 0, 0);
    chk("or_pass", 1, 4'(d_pass[1]), 4'd0);
    chk("or_fm",   1, d_fm[1],       4'b0110);
    chk("or_fm",   0, d_fm[0],       4'b0110);

    // start re-pulsed while busy is ignored
    mode = C_MD_AND;
    run(12, 2, 0, 0, 0);
    chk("repulse_done_cnt", 0, 4'(done_n[0]), 4'd1);
    chk("repulse_busy",     0, 4'(busy_n[0]), 4'd4);
    chk("repulse_pass",     0, 4'(d_pass[0]), 4'd1);
    chk("repulse_done_cnt", 1, 4'(done_n[1]), 4'd1);

    // reset while {a,b}=10 on the SETTLE=1 instance
    run(5, 0, 0, 5, 0);
    for (int i = 0; i < 2; i++) begin
      chk("mrst_ab",   i, 4'({d_a[i], d_b[i]}), 4'd0);
      chk("mrst_busy", i, 4'(d_busy[i]), 4'd0);
      chk("mrst_done", i, 4'(d_done[i]), 4'd0);
      chk("mrst_pass", i, 4'(d_pass[i]), 4'd0);
      chk("mrst_fm",   i, d_fm[i],       4'd0);
    end
    run(12, 0, 0, 0, 0);
    chk("post_rst_pass", 1, 4'(d_pass[1]),  4'd1);
    chk("post_rst_done", 1, 4'(done_n[1]),  4'd1);

    // abort in the SAMPLE cycle of vector 1 (SETTLE=1 instance)
    mode = C_MD_S0;
    truth_tbl = 4'b1111;
    run(12, 0, 4, 0, 0);
    chk("abort_done_cnt", 1, 4'(done_n[1]), 4'd0);
    chk("abort_pass",     1, 4'(d_pass[1]), 4'd0);
    chk("abort_fm",       1, d_fm[1],       4'b0001);
    chk("abort_busy",     1, 4'(busy_n[1]), 4'd4);
    chk("abort_fm",       0, d_fm[0],       4'b0111);
    chk("abort_done_cnt", 0, 4'(done_n[0]), 4'd0);

    cmp_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/gate_test_ctrl.md
GATE_TEST_CTRL -- requirements
Module: gate_test_ctrl

Interface
REQ-001 Parameter SETTLE, default 1: wait cycles per input vector before f is sampled; legal range 0..15.
REQ-002 clk  input  1  single clock; all state changes on posedge clk.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 start  input  1  request to begin a sweep; sampled in IDLE only.
REQ-005 abort  input  1  terminate an active sweep.
REQ-006 truth_tbl  input  4  expected gate output; bit i applies to vector i = {a,b}.
REQ-007 f  input  1  output of the 2-input gate under test.
REQ-008 a  output  1  gate input A = vector index bit 1.
REQ-009 b  output  1  gate input B = vector index bit 0.
REQ-010 busy  output  1  high while a sweep is in progress.
REQ-011 done  output  1  one-cycle pulse at sweep completion.
REQ-012 pass  output  1  sweep result, valid from done until the next accepted start.
REQ-013 fail_mask  output  4  bit i set when vector i mismatched.

Function
REQ-014 The block SHALL implement an FSM with states IDLE, WAIT, SAMPLE and DONE.
REQ-015 In IDLE with start=1 and abort=0, the block SHALL:
- latch truth_tbl;
- clear vector index, fail_mask and pass;
- enter WAIT, or SAMPLE when SETTLE=0.
REQ-016 start SHALL be ignored in WAIT, SAMPLE and DONE.
REQ-017 In IDLE, start and abort high together SHALL leave the block in IDLE.
REQ-018 {a,b} SHALL equal the 2-bit vector index throughout WAIT and SAMPLE, and SHALL be 2'b00 in IDLE and DONE.
REQ-019 WAIT SHALL last exactly SETTLE cycles (down-counter loaded with SETTLE-1), then enter SAMPLE.
REQ-020 SAMPLE SHALL last one cycle; at its closing edge fail_mask[idx] SHALL be set if f != latched truth_tbl[idx].
REQ-021 After SAMPLE, an index < 3 SHALL increment and return to WAIT (or SAMPLE when SETTLE=0); index 3 SHALL enter DONE with no wrap to 0.
REQ-022 Each vector SHALL occupy SETTLE+1 cycles, so busy SHALL be high for exactly 4*(SETTLE+1) cycles.
REQ-023 DONE SHALL last one cycle, with:
- done=1 and busy=0;
- pass = (fail_mask == 4'b0000);
- next state IDLE.
REQ-024 pass and fail_mask SHALL hold their values in IDLE until the next accepted start.
REQ-025 abort=1 in WAIT or SAMPLE SHALL return the block to IDLE at the next edge, with:
- no done pulse and pass=0;
- fail_mask retaining bits already recorded;
- the current SAMPLE compare discarded.
REQ-026 abort in IDLE or DONE SHALL have no effect.
REQ-027 truth_tbl changes after start is accepted SHALL NOT affect the sweep in progress.

Reset
REQ-028 rst_n=0 at a clock edge SHALL force, in any state including mid-sweep:
- state IDLE;
- a=0, b=0, busy=0, done=0, pass=0;
- fail_mask=4'b0000;
- internal index and counters to 0.
REQ-029 No sweep SHALL begin until start is sampled high with rst_n=1.

Verification
REQ-030 The bench SHALL cover these directed scenarios:
- SETTLE=1, truth_tbl=4'b1000, f=a&b, start pulsed one cycle -> {a,b} steps 00,01,10,11 for 2 cycles each, busy high 8 cycles, done on the 9th cycle after start is sampled, pass=1, fail_mask=4'b0000.
- SETTLE=1, truth_tbl=4'b1000, f stuck at 0 -> pass=0, fail_mask=4'b1000.
- SETTLE=1, truth_tbl=4'b1000, f=a|b -> pass=0, fail_mask=4'b0110.
- SETTLE=0, truth_tbl=4'b1000, f=a&b -> busy high 4 cycles, pass=1; start re-pulsed while busy -> ignored, exactly one done.
- rst_n=0 while {a,b}=2'b10 -> next cycle all outputs 0 and state IDLE; a subsequent start runs a full correct sweep.
- abort=1 in the SAMPLE cycle of vector 1 with f stuck at 0 and truth_tbl=4'b1111 -> IDLE next edge, no done, pass=0, fail_mask=4'b0001.
